// File: rtl/gate_vector_checker.sv
// Power-on self-test for the 4-function gate unit: sweeps all 16 {sel,A,B} vectors and
// reports mismatches. Define STOP_ON_FAIL_EN to stop the sweep at the first mismatch.
module gate_vector_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [1:0] gate_sel,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       err_q, err_d;
    logic [3:0]       ffi_q, ffi_d;

    logic golden;
    logic mismatch;

    always_comb begin
        golden = 1'b0;
        case (idx_q[3:2])
            2'b00: golden = ~idx_q[1];
            2'b01: golden = idx_q[1] & idx_q[0];
            2'b10: golden = idx_q[1] | idx_q[0];
            2'b11: golden = idx_q[1] ^ idx_q[0];
            default: golden = 1'b0;
        endcase
    end

    assign mismatch = (gate_y != golden);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ffi_d   = ffi_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_APPLY;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                    err_d   = 5'd0;
                    ffi_d   = 4'd0;
                end
            end

            S_APPLY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 5'd1;
                    if (err_q == 5'd0) begin
                        ffi_d = idx_q;
                    end
                end
`ifdef STOP_ON_FAIL_EN
                // Leaving idx untouched keeps the failing vector on the drive pins for debug.
                if (mismatch || idx_q == 4'd15) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_APPLY;
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = '0;
                end
`else
                if (idx_q == 4'd15) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_APPLY;
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = '0;
                end
`endif
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            err_q   <= 5'd0;
            ffi_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ffi_q   <= ffi_d;
        end
    end

    // Drive pins come straight from the idx register, so they never glitch.
    assign gate_sel       = idx_q[3:2];
    assign gate_a         = idx_q[1];
    assign gate_b         = idx_q[0];

    assign busy           = (state_q == S_APPLY) || (state_q == S_CHECK);
    assign done           = (state_q == S_DONE);
    assign pass           = done && (err_q == 5'd0);
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Self-checking bench for gate_vector_checker: a behavioural gate unit with selectable
// faults, a table of sweep scenarios, and hand-written reset / restart / extra-start cases.
module tb_gate_vector_checker;

    localparam int SETTLE = 2;
    localparam int SWEEP  = 16 * (SETTLE + 1);
    localparam int BUDGET = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] gate_sel;
    logic       gate_a;
    logic       gate_b;
    logic       gate_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_fail_idx;

    int checks = 0;
    int errors = 0;

    // 0 = correct unit, 1 = XOR replaced by OR, 2 = Y stuck at 0
    int fault_mode = 0;

    typedef struct packed {
        logic [4:0] err;
        logic [3:0] ffi;
        logic       pass;
    } result_t;

    typedef struct {
        int         mode;
        logic [4:0] err;
        logic [3:0] ffi;
        logic       pass;
    } vec_t;

    result_t sb_q[$];

    gate_vector_checker #(
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .gate_sel      (gate_sel),
        .gate_a        (gate_a),
        .gate_b        (gate_b),
        .gate_y        (gate_y),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;

    always_comb begin
        gate_y = 1'b0;
        case (gate_sel)
            2'b00: gate_y = ~gate_a;
            2'b01: gate_y = gate_a & gate_b;
            2'b10: gate_y = gate_a | gate_b;
            2'b11: gate_y = (fault_mode == 1) ? (gate_a | gate_b) : (gate_a ^ gate_b);
            default: gate_y = 1'b0;
        endcase
        if (fault_mode == 2) gate_y = 1'b0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_pass"}, pass, 0);
        check({name, "_err"}, err_count, 0);
        check({name, "_ffi"}, first_fail_idx, 0);
        check({name, "_drive"}, {gate_sel, gate_a, gate_b}, 0);
    endtask

    // Pulses start, then clocks until done. poke_at>0 raises start again at that cycle;
    // rst_at>0 asserts reset (together with start) at that cycle and abandons the sweep.
    task automatic run_sweep(input int poke_at, input int rst_at, input vec_t exp_v);
        result_t r;
        int      n;
        int      bad;
        bit      finished;
        bit      aborted;

        r.err  = exp_v.err;
        r.ffi  = exp_v.ffi;
        r.pass = exp_v.pass;
        sb_q.push_back(r);

        start = 1'b1;
        step();
        start = 1'b0;
        check("start_accept", {busy, done, pass, err_count, first_fail_idx, gate_sel, gate_a, gate_b},
              {1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 2'd0, 1'b0, 1'b0});

        n = 0;
        bad = 0;
        finished = 1'b0;
        aborted = 1'b0;
        while (!finished && !aborted && n < BUDGET) begin
            n++;
            start = (n == poke_at) || (n == rst_at);
            rst_n = (n != rst_at);
            step();
            start = 1'b0;
            rst_n = 1'b1;
            if (n == rst_at) aborted = 1'b1;
            else if (done) finished = 1'b1;
            else if ({gate_sel, gate_a, gate_b} != 4'(n / (SETTLE + 1)) || !busy) bad++;
        end

        if (aborted) begin
            sb_q.delete();
            check_all_zero("mid_reset");
            return;
        end

        check("done_seen", finished, 1);
        if (!finished) begin
            sb_q.delete();
            return;
        end
        check("sweep_len", n, SWEEP);
        check("drive_seq_bad_cycles", bad, 0);
        check("busy_at_done", busy, 0);
        check("drive_final", {gate_sel, gate_a, gate_b}, 4'hF);

        r = sb_q.pop_front();
        check("err_count", err_count, r.err);
        check("first_fail_idx", first_fail_idx, r.ffi);
        check("pass", pass, r.pass);

        step();
        check("done_hold", {done, err_count, first_fail_idx}, {1'b1, r.err, r.ffi});
    endtask

    vec_t tbl[3];
    vec_t good;

    initial begin
        tbl[0] = '{mode: 0, err: 5'd0, ffi: 4'h0, pass: 1'b1};
        tbl[1] = '{mode: 1, err: 5'd1, ffi: 4'hF, pass: 1'b0};
        tbl[2] = '{mode: 2, err: 5'd8, ffi: 4'h0, pass: 1'b0};
        good   = tbl[0];

        rst_n = 1'b0;
        start = 1'b1;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        start = 1'b0;
        step();
        check_all_zero("idle");

        for (int i = 0; i < 3; i++) begin
            fault_mode = tbl[i].mode;
            run_sweep(0, 0, tbl[i]);
        end

        // Restart from DONE after the failing run, with an ignored start at cycle 10.
        fault_mode = 0;
        run_sweep(10, 0, good);

        // Reset (with start high) at cycle 20, then a fresh full sweep.
        run_sweep(0, 20, good);
        step();
        check("post_reset_idle", {busy, done}, 2'b00);
        run_sweep(0, 0, good);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
